piso_shift_register: RTL
========================

// Module: piso_shift_register
// PURPOSE
//   Parallel-in/serial-out transmitter: accepts a WIDTH-bit word with a load/ready
//   handshake and shifts it onto serial_out, one bit per clk cycle.
//   Transmit end of the team's serial link; pairs with a serial-in/parallel-out
//   receiver that shifts left, so the first bit sent ends in q[WIDTH-1].
//   bit_valid and last frame the stream so a receiver can gate capture and
//   detect word boundaries.
// PARAMETERS
//   WIDTH      4   word width in bits; legal range >= 2
//   MSB_FIRST  1   1: data_in[WIDTH-1] is sent first; 0: data_in[0] is sent first
// PORTS
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   load       in   1      word-valid; the word is accepted on a clk edge where load && ready
//   data_in    in   WIDTH  parallel word, sampled only at accept
//   ready      out  1      transmitter can accept a word this cycle
//   serial_out out  1      serial data
//   bit_valid  out  1      serial_out carries a valid data bit this cycle
//   last       out  1      serial_out carries the final bit of the current word
// BEHAVIOUR
//   - Single clock domain; all outputs registered.
//   - Reset (async, immediate, regardless of clk):
//     - State: state=IDLE, shift reg=0, bit counter=0.
//     - Outputs: serial_out=0, bit_valid=0, last=0, ready=1.
//   - FSM has two states, IDLE and SHIFT.
//   - IDLE:
//     - ready=1, bit_valid=0, last=0, serial_out=0.
//     - On an edge with load=1: latch data_in, clear the counter, go to SHIFT.
//   - SHIFT:
//     - Accepted at edge T0 -> bits appear in cycles T0+1 .. T0+WIDTH, each held exactly one cycle.
//     - bit_valid=1 throughout SHIFT.
//     - Counter runs 0..WIDTH-1 and is $clog2(WIDTH) bits wide.
//     - last=1 only when counter==WIDTH-1.
//     - ready=0 while counter<WIDTH-1; ready=1 in the last-bit cycle.
//     - Bit order: MSB_FIRST=1 shifts left and drives the MSB; MSB_FIRST=0 shifts right and drives the LSB.
//   - End of word (edge ending the last-bit cycle):
//     - If load=1: accept the new word, stay in SHIFT, reset the counter. The next word starts
//       with no gap and bit_valid stays 1.
//     - If load=0: return to IDLE; serial_out and bit_valid drop to 0 the next cycle.
//   - load while ready=0: ignored, data_in not sampled, no effect on the stream.
//   - data_in changes after accept: no effect on the word in flight.
//   - rst mid-word: word aborted and not resumed; the next word needs a new load after rst falls.
//   - No X on any output after reset; outputs stay stable between edges.
// TESTING  (clk period 10ns, WIDTH=4 unless noted)
//   1. Assert rst mid-word (cycle 2 of 1011)
//      -> serial_out=0, bit_valid=0, last=0, ready=1 immediately.
//      -> After release, idle until the next load.
//   2. load=1, data_in=4'b1011 for one edge (MSB_FIRST=1)
//      -> serial_out=1,0,1,1 on the next 4 cycles; bit_valid=1 on all 4; last=1 on the 4th only.
//      -> ready=0 on cycles 1-3, then IDLE.
//   3. Accept 4'b1011; hold load=1 with data_in=4'b0110 during bit cycles 1-2
//      -> stream stays 1,0,1,1; 0110 is not sampled.
//   4. Accept 4'b1011, then load=1, data_in=4'b0100 in its last-bit cycle
//      -> 8 contiguous bits 1,0,1,1,0,1,0,0; bit_valid stays high; last on bits 4 and 8.
//   5. MSB_FIRST=0, data_in=4'b1011 -> serial_out=1,1,0,1.
//   6. Loopback into the 4-bit left-shifting receiver, gated by bit_valid, data_in=4'b1101
//      -> receiver q==4'b1101 on the cycle after last.

Source files
------------

// File: rtl/piso_shift_register.sv
// Parallel-in/serial-out transmitter: a WIDTH-bit word goes out on serial_out, one bit per clk.
// Latency: the word is accepted at edge T0 and its bits occupy cycles T0+1 .. T0+WIDTH.
// Backpressure: ready is low while a word is shifting. It rises in the last-bit cycle so the next word can follow with no gap.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   load, data_in      word offer; the word is taken on an edge where load && ready
//   ready              transmitter can take a word this cycle
//   serial_out         serial data bit
//   bit_valid, last    framing: bit present / final bit of the word
module piso_shift_register #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   output logic             ready,
   output logic             serial_out,
   output logic             bit_valid,
   output logic             last
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;

   // The first bit goes straight to serial_out at accept time. The shift
   // register keeps only the bits still to be sent, which is why the
   // shifted copy of data_in is loaded rather than data_in itself.
   logic             data_first;
   logic [WIDTH-1:0] data_rest;
   logic             shreg_first;
   logic [WIDTH-1:0] shreg_rest;

   assign data_first  = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
   assign data_rest   = MSB_FIRST ? (data_in << 1)   : (data_in >> 1);
   assign shreg_first = MSB_FIRST ? shreg[WIDTH-1]   : shreg[0];
   assign shreg_rest  = MSB_FIRST ? (shreg << 1)     : (shreg >> 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         shreg      <= '0;
         cnt        <= '0;
         serial_out <= 1'b0;
         bit_valid  <= 1'b0;
         last       <= 1'b0;
         ready      <= 1'b1;
      end else if (load && ready) begin
         // ready is high only in IDLE or in the last-bit cycle, so this
         // covers both a fresh start and a gapless back-to-back word.
         state      <= SHIFT;
         shreg      <= data_rest;
         cnt        <= '0;
         serial_out <= data_first;
         bit_valid  <= 1'b1;
         last       <= 1'b0;
         ready      <= 1'b0;
      end else if (state == SHIFT && cnt != CNT_LAST) begin
         cnt        <= cnt + CW'(1);
         shreg      <= shreg_rest;
         serial_out <= shreg_first;
         bit_valid  <= 1'b1;
         // The counter is moving to WIDTH-1. That makes the next cycle the
         // last-bit cycle, which is also the cycle in which ready reopens.
         last       <= (cnt == CNT_PENULT);
         ready      <= (cnt == CNT_PENULT);
      end else begin
         state      <= IDLE;
         cnt        <= '0;
         serial_out <= 1'b0;
         bit_valid  <= 1'b0;
         last       <= 1'b0;
         ready      <= 1'b1;
      end
   end

endmodule
